// File: rtl/kamikaze_mem_arbiter.sv
// kamikaze_mem_arbiter: shares one instruction/data memory port between the
// fetch FIFO (read-only, word-aligned) and the load/store unit.
// Data normally wins arbitration; a streak limit lets a waiting fetch through.
// Optional macro KAMIKAZE_ARB_ROUND_ROBIN_EN replaces the streak limit with
// simple alternation between the two requesters.
module kamikaze_mem_arbiter #(
  parameter int DATA_STREAK_MAX = 4,
  parameter int STREAK_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  input  logic        branch_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_t      state_q, state_nxt;
  logic        owner_q;
  logic        abort_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        grant_f;
  logic        grant_d;
  logic        if_cand;
  logic        unused_addr_bits;

  // Word alignment means the low address bits never reach the memory.
  assign unused_addr_bits = ^{if_addr_i[1:0], d_addr_i[1:0]};

  // A branch in the same cycle makes the fetch address stale, so it cannot win.
  assign if_cand = if_req_i && !branch_i;

`ifdef KAMIKAZE_ARB_ROUND_ROBIN_EN
  logic                last_owner_q;
  logic [STREAK_W-1:0] unused_streak_cfg;

  assign unused_streak_cfg = STREAK_W'(DATA_STREAK_MAX);

  // Arbitration in IDLE: on contention, the requester not served last wins.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (if_cand && d_req_i) begin
        if (last_owner_q == OWN_DATA) grant_f = 1'b1;
        else                          grant_d = 1'b1;
      end else if (d_req_i) begin
        grant_d = 1'b1;
      end else if (if_cand) begin
        grant_f = 1'b1;
      end
    end
  end

  // Remember who was served last so contention alternates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       last_owner_q <= OWN_FETCH;
    else if (grant_f) last_owner_q <= OWN_FETCH;
    else if (grant_d) last_owner_q <= OWN_DATA;
  end
`else
  logic [STREAK_W-1:0] streak_q;
  logic                streak_full;

  assign streak_full = (streak_q == STREAK_W'(DATA_STREAK_MAX));

  // Arbitration in IDLE: data wins contention until fetch has waited too long.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (if_cand && d_req_i) begin
        if (streak_full) grant_f = 1'b1;
        else             grant_d = 1'b1;
      end else if (d_req_i) begin
        grant_d = 1'b1;
      end else if (if_cand) begin
        grant_f = 1'b1;
      end
    end
  end

  // Count data grants that kept fetch waiting; any relief resets the count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      streak_q <= '0;
    end else if (grant_f) begin
      streak_q <= '0;
    end else if (grant_d) begin
      if (!if_req_i)         streak_q <= '0;
      else if (!streak_full) streak_q <= streak_q + STREAK_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next state: grant -> hold request until ack -> one response cycle.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (grant_f || grant_d) state_nxt = ISSUE;
      ISSUE:   if (mem_ack_i)          state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request, track branch aborts and capture read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q    <= OWN_FETCH;
      abort_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_f) begin
        owner_q <= OWN_FETCH;
        addr_q  <= {if_addr_i[31:2], 2'b00};
        we_q    <= 1'b0;
        be_q    <= 4'hF;
        wdata_q <= '0;
      end else if (grant_d) begin
        owner_q <= OWN_DATA;
        addr_q  <= {d_addr_i[31:2], 2'b00};
        we_q    <= d_we_i;
        be_q    <= d_be_i;
        wdata_q <= d_wdata_i;
      end
      if (state_q == ISSUE) begin
        if (owner_q == OWN_FETCH && branch_i) abort_q <= 1'b1;
        if (mem_ack_i) begin
          if (owner_q == OWN_DATA)          d_rdata_q  <= mem_rdata_i;
          else if (!abort_q && !branch_i)   if_rdata_q <= mem_rdata_i;
        end
      end
      if (state_q == RESP) abort_q <= 1'b0;
    end
  end

  assign mem_req_o   = (state_q == ISSUE);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ready_o  = (state_q == RESP) && (owner_q == OWN_FETCH) && !abort_q && !branch_i;
  assign d_ready_o   = (state_q == RESP) && (owner_q == OWN_DATA);

endmodule

// File: tb/tb_kamikaze_mem_arbiter.sv
// Directed testbench for kamikaze_mem_arbiter with a latency-programmable
// memory responder. Honours KAMIKAZE_ARB_ROUND_ROBIN_EN for the grant order.
module tb_kamikaze_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_be_i = '0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic [31:0] d_rdata_o;
  logic        d_ready_o;
  logic        branch_i = 1'b0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          issue_cnt = 0;
  logic [31:0] resp_data = '0;

  kamikaze_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .branch_i(branch_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Memory model: acks in the lat-th cycle that mem_req_o is seen high.
  always @(negedge clk_i) begin
    if (mem_req_o) begin
      issue_cnt   = issue_cnt + 1;
      mem_ack_i   = (issue_cnt == lat);
      mem_rdata_i = mem_ack_i ? resp_data : 32'h0;
    end else begin
      issue_cnt   = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Directed scenarios.
  initial begin : stimulus
    int n;
    logic prev_req;
    logic exp_data;

    // Reset state.
    step(); step();
    check_output("rst_mem_req", 32'(mem_req_o), 32'h0);
    check_output("rst_if_ready", 32'(if_ready_o), 32'h0);
    check_output("rst_d_ready", 32'(d_ready_o), 32'h0);
    check_output("rst_if_rdata", if_rdata_o, 32'h0);
    check_output("rst_d_rdata", d_rdata_o, 32'h0);
    check_output("rst_mem_addr", mem_addr_o, 32'h0);
    rst_i = 1'b1;
    step();

    // Fetch only, unaligned address, two-cycle memory latency.
    lat = 2; resp_data = 32'h00A00093;
    if_req_i = 1'b1; if_addr_i = 32'h00000106;
    step();
    check_output("f_mem_req", 32'(mem_req_o), 32'h1);
    check_output("f_mem_addr", mem_addr_o, 32'h00000104);
    check_output("f_mem_be", 32'(mem_be_o), 32'hF);
    check_output("f_mem_we", 32'(mem_we_o), 32'h0);
    step();
    check_output("f_req_held", 32'(mem_req_o), 32'h1);
    check_output("f_ready_early", 32'(if_ready_o), 32'h0);
    step();
    check_output("f_ready", 32'(if_ready_o), 32'h1);
    check_output("f_rdata", if_rdata_o, 32'h00A00093);
    check_output("f_d_ready", 32'(d_ready_o), 32'h0);
    if_req_i = 1'b0;
    step();
    check_output("f_ready_pulse", 32'(if_ready_o), 32'h0);

    // Data write, one-cycle latency.
    lat = 1; resp_data = 32'h0;
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h20; d_wdata_i = 32'hDEADBEEF;
    step();
    check_output("w_mem_we", 32'(mem_we_o), 32'h1);
    check_output("w_mem_be", 32'(mem_be_o), 32'h3);
    check_output("w_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    check_output("w_mem_addr", mem_addr_o, 32'h20);
    step();
    check_output("w_d_ready", 32'(d_ready_o), 32'h1);
    check_output("w_if_ready", 32'(if_ready_o), 32'h0);
    d_req_i = 1'b0; d_we_i = 1'b0;
    step();
    check_output("w_d_ready_pulse", 32'(d_ready_o), 32'h0);

    // Branch in the same IDLE cycle blocks the fetch; branch in RESP gates ready.
    lat = 1; resp_data = 32'h44444444;
    if_req_i = 1'b1; if_addr_i = 32'h50; branch_i = 1'b1;
    step();
    check_output("bi_no_grant", 32'(mem_req_o), 32'h0);
    branch_i = 1'b0;
    step();
    check_output("bi_grant", 32'(mem_req_o), 32'h1);
    check_output("bi_addr", mem_addr_o, 32'h50);
    step();
    check_output("bi_ready", 32'(if_ready_o), 32'h1);
    branch_i = 1'b1;
    #1;
    check_output("bi_ready_gated", 32'(if_ready_o), 32'h0);
    if_req_i = 1'b0;
    step();
    branch_i = 1'b0;

    // Branch while a fetch is in ISSUE: cycle completes, response dropped.
    lat = 3; resp_data = 32'h11111111;
    if_req_i = 1'b1; if_addr_i = 32'h80;
    step();
    branch_i = 1'b1; if_req_i = 1'b0;
    step();
    branch_i = 1'b0;
    check_output("ab_req_held1", 32'(mem_req_o), 32'h1);
    step();
    check_output("ab_req_held2", 32'(mem_req_o), 32'h1);
    step();
    check_output("ab_no_ready", 32'(if_ready_o), 32'h0);
    step();
    lat = 1; resp_data = 32'h22222222;
    if_req_i = 1'b1; if_addr_i = 32'h40;
    step();
    check_output("ab_next_addr", mem_addr_o, 32'h40);
    step();
    check_output("ab_next_ready", 32'(if_ready_o), 32'h1);
    check_output("ab_next_rdata", if_rdata_o, 32'h22222222);
    if_req_i = 1'b0;
    step();

    // Data read with branch asserted: never aborted.
    lat = 2; resp_data = 32'hCAFEF00D;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h24;
    step();
    branch_i = 1'b1;
    step();
    step();
    check_output("dr_ready", 32'(d_ready_o), 32'h1);
    check_output("dr_rdata", d_rdata_o, 32'hCAFEF00D);
    d_req_i = 1'b0; branch_i = 1'b0;
    step();

    // Reset during ISSUE drops everything at once.
    lat = 3; resp_data = 32'h0;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    step();
    check_output("rs_req_before", 32'(mem_req_o), 32'h1);
    #1 rst_i = 1'b0;
    #1;
    check_output("rs_mem_req", 32'(mem_req_o), 32'h0);
    check_output("rs_if_ready", 32'(if_ready_o), 32'h0);
    check_output("rs_d_ready", 32'(d_ready_o), 32'h0);
    check_output("rs_d_rdata", d_rdata_o, 32'h0);
    step();
    rst_i = 1'b1;
    lat = 1; resp_data = 32'h33333333;
    step();
    check_output("rs_fresh_req", 32'(mem_req_o), 32'h1);
    step();
    check_output("rs_fresh_ready", 32'(if_ready_o), 32'h1);
    check_output("rs_fresh_rdata", if_rdata_o, 32'h33333333);
    if_req_i = 1'b0;
    step();

    // Both requesters held: record the order of the first ten grants.
    lat = 1; resp_data = 32'h0;
    if_req_i = 1'b1; if_addr_i = 32'h200;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
    n = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      step();
      if (mem_req_o && !prev_req) begin
`ifdef KAMIKAZE_ARB_ROUND_ROBIN_EN
        exp_data = (n % 2 == 0);
`else
        exp_data = (n % 5 != 4);
`endif
        check_output($sformatf("grant%0d_is_data", n), 32'(mem_addr_o == 32'h300), 32'(exp_data));
        n++;
      end
      prev_req = mem_req_o;
    end
    check_output("grant_count", 32'(n), 32'd10);
    if_req_i = 1'b0; d_req_i = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
